// File: rtl/regfile_sweep.sv
// 32x32 register file with combinational reads, one write port and a reset-time clear sweep.
// Optional same-cycle write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sweep (
  input  logic        Clk,
  input  logic        ResetN,
  input  logic [4:0]  ReadRegister1,
  input  logic [4:0]  ReadRegister2,
  input  logic [4:0]  WriteRegister,
  input  logic [31:0] WriteData,
  input  logic        RegWrite,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  output logic        Busy,
  output logic        ClearDone
);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t      r_state;
  logic [4:0]  r_ptr;
  logic        r_busy;
  logic        r_clear_done;
  logic [31:0] r_mem [0:31];

  logic        w_we;
  logic [4:0]  w_waddr;
  logic [31:0] w_wdata;

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      r_state      <= ST_CLEAR;
      r_ptr        <= 5'd1;
      r_busy       <= 1'b1;
      r_clear_done <= 1'b0;
    end else begin
      r_clear_done <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          if (r_ptr == 5'd31) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_clear_done <= 1'b1;
          end else begin
            r_ptr <= r_ptr + 5'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // The sweep and the initiator share one write port so the array maps onto a simple RAM.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_ptr;
    w_wdata = '0;
    if (ResetN) begin
      if (r_state == ST_CLEAR) begin
        w_we = 1'b1;
      end else if (RegWrite && (WriteRegister != 5'd0)) begin
        w_we    = 1'b1;
        w_waddr = WriteRegister;
        w_wdata = WriteData;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // Entry 0 is never written; the address-0 and CLEAR masks make its contents irrelevant.
  always_comb begin
    ReadData1 = r_mem[ReadRegister1];
`ifdef REGFILE_BYPASS_EN
    if ((r_state == ST_IDLE) && RegWrite && (WriteRegister != 5'd0) &&
        (WriteRegister == ReadRegister1))
      ReadData1 = WriteData;
`endif
    if ((r_state != ST_IDLE) || (ReadRegister1 == 5'd0)) ReadData1 = '0;
  end

  always_comb begin
    ReadData2 = r_mem[ReadRegister2];
`ifdef REGFILE_BYPASS_EN
    if ((r_state == ST_IDLE) && RegWrite && (WriteRegister != 5'd0) &&
        (WriteRegister == ReadRegister2))
      ReadData2 = WriteData;
`endif
    if ((r_state != ST_IDLE) || (ReadRegister2 == 5'd0)) ReadData2 = '0;
  end

  assign Busy      = r_busy;
  assign ClearDone = r_clear_done;

endmodule

// File: tb/tb_regfile_sweep.sv
// Self-checking bench for regfile_sweep: vector table, sweep timing sequences and
// randomized traffic against an array model (honours REGFILE_BYPASS_EN like the DUT).
module tb_regfile_sweep;

  logic        Clk;
  logic        ResetN;
  logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [31:0] ReadData1, ReadData2;
  logic        Busy, ClearDone;

  regfile_sweep dut (
    .Clk(Clk), .ResetN(ResetN),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .Busy(Busy), .ClearDone(ClearDone)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] model [0:31];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;
  vec_t vecs [5];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  // Expected read value before the edge, given the inputs currently driven.
  function automatic logic [31:0] exp_pre(input logic [4:0] ra);
    if (ra == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && (WriteRegister != 5'd0) && (WriteRegister == ra)) return WriteData;
`endif
    return model[ra];
  endfunction

  task automatic model_write();
    if (RegWrite && (WriteRegister != 5'd0)) model[WriteRegister] = WriteData;
  endtask

  // Release reset, count edges until Busy falls; checks latency and the single ClearDone pulse.
  task automatic run_sweep(input string tag);
    int fall = 0;
    int pulses = 0;
    int early_pulse = 0;
    int nonzero_reads = 0;
    ResetN = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (ClearDone) begin
        pulses++;
        if (Busy) early_pulse++;
      end
      if (Busy && (ReadData1 != 0 || ReadData2 != 0)) nonzero_reads++;
      if (!Busy) begin
        fall = k;
        break;
      end
    end
    check({tag, "_busy_fall_edge"}, fall, 31);
    check({tag, "_cleardone_pulses"}, pulses, 1);
    check({tag, "_cleardone_while_busy"}, early_pulse, 0);
    check({tag, "_reads_masked_in_clear"}, nonzero_reads, 0);
    RegWrite = 1'b0;
    tick();
    check({tag, "_cleardone_one_cycle"}, ClearDone, 1'b0);
    check({tag, "_busy_stays_low"}, Busy, 1'b0);
    model_clear();
  endtask

  initial begin
    ResetN = 1'b0; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;

    vecs[0] = '{1'b1, 5'd2, 32'd42, 5'd2, 5'd2, 32'd42, 32'd42};
    vecs[1] = '{1'b1, 5'd2, 32'd15, 5'd2, 5'd2, 32'd15, 32'd15};
    vecs[2] = '{1'b0, 5'd2, 32'd32, 5'd2, 5'd2, 32'd15, 32'd15};
    vecs[3] = '{1'b1, 5'd0, 32'd15, 5'd0, 5'd0, 32'd0,  32'd0};
    vecs[4] = '{1'b1, 5'd3, 32'd9,  5'd3, 5'd17, 32'd9, 32'd0};

    // Reset for two edges, then sweep.
    tick(); tick();
    check("rst_busy", Busy, 1'b1);
    check("rst_cleardone", ClearDone, 1'b0);
    ReadRegister1 = 5'd9; ReadRegister2 = 5'd31; #1;
    check("rst_rd1", ReadData1, 32'd0);
    check("rst_rd2", ReadData2, 32'd0);
    run_sweep("sweep1");

    for (int a = 0; a < 32; a++) begin
      ReadRegister1 = a[4:0]; ReadRegister2 = 5'(31 - a); #1;
      check($sformatf("clr_rd1_r%0d", a), ReadData1, 32'd0);
      check($sformatf("clr_rd2_r%0d", 31 - a), ReadData2, 32'd0);
    end

    // Table vectors: drive, clock, compare after the edge.
    for (int i = 0; i < 5; i++) begin
      RegWrite = vecs[i].we; WriteRegister = vecs[i].wa; WriteData = vecs[i].wd;
      ReadRegister1 = vecs[i].ra1; ReadRegister2 = vecs[i].ra2;
      model_write();
      tick();
      RegWrite = 1'b0;
      #1;
      check($sformatf("vec%0d_rd1", i), ReadData1, vecs[i].exp1);
      check($sformatf("vec%0d_rd2", i), ReadData2, vecs[i].exp2);
    end

    // Bypass: same-cycle read of the register being written.
    RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 32'hA5A5A5A5;
    ReadRegister1 = 5'd7; ReadRegister2 = 5'd0; #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_pre_edge", ReadData1, 32'hA5A5A5A5);
`else
    check("byp_pre_edge", ReadData1, 32'd0);
`endif
    check("byp_r0_pre_edge", ReadData2, 32'd0);
    model_write();
    tick();
    RegWrite = 1'b0; #1;
    check("byp_post_edge", ReadData1, 32'hA5A5A5A5);

    // Randomized traffic against the array model.
    for (int n = 0; n < 300; n++) begin
      RegWrite = ($urandom_range(0, 3) != 0);
      WriteRegister = 5'($urandom_range(0, 31));
      WriteData = $urandom();
      ReadRegister1 = ($urandom_range(0, 2) == 0) ? WriteRegister : 5'($urandom_range(0, 31));
      ReadRegister2 = 5'($urandom_range(0, 31));
      #1;
      check($sformatf("rnd%0d_pre_rd1", n), ReadData1, exp_pre(ReadRegister1));
      check($sformatf("rnd%0d_pre_rd2", n), ReadData2, exp_pre(ReadRegister2));
      model_write();
      tick();
      RegWrite = 1'b0; #1;
      check($sformatf("rnd%0d_post_rd1", n), ReadData1, model[ReadRegister1]);
      check($sformatf("rnd%0d_post_rd2", n), ReadData2, model[ReadRegister2]);
    end

    // Put known data in reg 5 so the later clear has something to erase.
    RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 32'h00001234;
    model_write();
    tick();
    RegWrite = 1'b0; ReadRegister1 = 5'd5; #1;
    check("pre_mid_r5", ReadData1, 32'h00001234);

    // Mid-sweep reset with writes attempted throughout CLEAR.
    begin
      int pulses = 0;
      ResetN = 1'b0;
      tick();
      ResetN = 1'b1;
      RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 32'hDEADBEEF;
      ReadRegister1 = 5'd5; ReadRegister2 = 5'd2;
      #1;
      check("mid_unswept_rd1_masked", ReadData1, 32'd0);
      check("mid_unswept_rd2_masked", ReadData2, 32'd0);
      for (int k = 1; k <= 9; k++) begin
        tick();
        if (ClearDone) pulses++;
      end
      ResetN = 1'b0;
      tick();
      if (ClearDone) pulses++;
      check("mid_no_cleardone_before_restart", pulses, 0);
      check("mid_busy_in_reset", Busy, 1'b1);
      run_sweep("sweep2");
    end
    ReadRegister1 = 5'd5; ReadRegister2 = 5'd7; #1;
    check("mid_r5_cleared", ReadData1, 32'd0);
    check("mid_r7_cleared", ReadData2, 32'd0);

    // First write after the sweep lands normally.
    RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 32'hCAFE0005;
    tick();
    RegWrite = 1'b0; #1;
    check("post_mid_write_r5", ReadData1, 32'hCAFE0005);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
